// File: rtl/standby_rx_packer.sv
// RX datapath for the I3C standby controller: packs received bytes little-endian into
// queue words and emits one RX descriptor per transfer (count, type, status).
module standby_rx_packer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned DescWidth = 32,
  parameter int unsigned MaxLen    = 4095
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 transfer_start_i,
  input  logic                 transfer_stop_i,
  input  logic [1:0]           transfer_type_i,
  input  logic                 rx_byte_valid_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 rx_byte_ready_o,
  output logic                 rx_queue_wvalid_o,
  input  logic                 rx_queue_wready_i,
  output logic [DataWidth-1:0] rx_queue_wdata_o,
  output logic                 rx_desc_queue_wvalid_o,
  input  logic                 rx_desc_queue_wready_i,
  output logic [DescWidth-1:0] rx_desc_queue_wdata_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int unsigned Lanes = DataWidth / 8;
  localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);
  localparam logic [15:0] MaxCount = 16'(MaxLen);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StDrain,
    StFlush,
    StDesc
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          count_q, count_d;
  logic [LaneW-1:0]     lane_q, lane_d;
  logic [DataWidth-1:0] word_q, word_d;
  logic [1:0]           type_q, type_d;
  logic                 err_q, err_d;
  // end_q: an end event is latched; rs_q: that end was a repeated START
  logic                 end_q, end_d;
  logic                 rs_q, rs_d;
  logic                 word_full;
  logic                 end_evt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      type_q  <= type_d;
      err_q   <= err_d;
      end_q   <= end_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lane_d    = lane_q;
    word_d    = word_q;
    type_d    = type_q;
    err_d     = err_q;
    end_d     = end_q;
    rs_d      = rs_q;
    word_full = 1'b0;
    end_evt   = transfer_start_i | transfer_stop_i;

    rx_byte_ready_o        = 1'b0;
    rx_queue_wvalid_o      = 1'b0;
    rx_desc_queue_wvalid_o = 1'b0;
    overflow_o             = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (transfer_start_i) begin
          state_d = StRecv;
          count_d = '0;
          lane_d  = '0;
          word_d  = '0;
          err_d   = 1'b0;
          end_d   = 1'b0;
          rs_d    = 1'b0;
        end
      end

      StRecv: begin
        rx_byte_ready_o = 1'b1;
        if (rx_byte_valid_i) begin
          type_d = transfer_type_i;
          if (count_q == MaxCount) begin
            // Byte is consumed but dropped; only the first drop pulses overflow.
            err_d      = 1'b1;
            overflow_o = ~err_q;
          end else begin
            for (int unsigned i = 0; i < Lanes; i++) begin
              if (lane_q == LaneW'(i)) begin
                word_d[8*i +: 8] = rx_byte_i;
              end
            end
            count_d = count_q + 16'd1;
            if (lane_q == LastLane) begin
              lane_d    = '0;
              word_full = 1'b1;
            end else begin
              lane_d = lane_q + LaneW'(1);
            end
          end
        end
        if (end_evt) begin
          end_d = 1'b1;
          rs_d  = transfer_start_i;
        end
        if (word_full) begin
          state_d = StDrain;
        end else if (end_evt) begin
          state_d = (lane_d != '0) ? StFlush : StDesc;
        end
      end

      StDrain: begin
        rx_queue_wvalid_o = 1'b1;
        if (transfer_start_i) begin
          end_d = 1'b1;
          rs_d  = 1'b1;
        end else if (transfer_stop_i && !end_q) begin
          end_d = 1'b1;
          rs_d  = 1'b0;
        end
        if (rx_queue_wready_i) begin
          word_d  = '0;
          state_d = end_d ? StDesc : StRecv;
        end
      end

      StFlush: begin
        rx_queue_wvalid_o = 1'b1;
        if (transfer_start_i) begin
          rs_d = 1'b1;
        end
        if (rx_queue_wready_i) begin
          word_d  = '0;
          lane_d  = '0;
          state_d = StDesc;
        end
      end

      StDesc: begin
        if (count_q == '0) begin
          // Address-only or aborted transfer: nothing to report.
          state_d = StIdle;
          end_d   = 1'b0;
          rs_d    = 1'b0;
        end else begin
          rx_desc_queue_wvalid_o = 1'b1;
          if (transfer_start_i) begin
            rs_d = 1'b1;
          end
          if (rx_desc_queue_wready_i) begin
            state_d = rs_d ? StRecv : StIdle;
            count_d = '0;
            lane_d  = '0;
            err_d   = 1'b0;
            end_d   = 1'b0;
            rs_d    = 1'b0;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (!enable_i) begin
      state_d                = StIdle;
      count_d                = '0;
      lane_d                 = '0;
      word_d                 = '0;
      err_d                  = 1'b0;
      end_d                  = 1'b0;
      rs_d                   = 1'b0;
      rx_byte_ready_o        = 1'b0;
      rx_queue_wvalid_o      = 1'b0;
      rx_desc_queue_wvalid_o = 1'b0;
      overflow_o             = 1'b0;
    end
  end

  always_comb begin
    rx_desc_queue_wdata_o        = '0;
    rx_desc_queue_wdata_o[15:0]  = count_q;
    rx_desc_queue_wdata_o[17:16] = type_q;
    rx_desc_queue_wdata_o[31:28] = err_q ? 4'd1 : 4'd0;
  end

  assign rx_queue_wdata_o = word_q;
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_standby_rx_packer.sv
// Bench for standby_rx_packer: three instances (32-bit, 8-bit, 32-bit with MaxLen=4) share
// one stimulus bus; table vectors plus directed multi-cycle sequences.
module tb_standby_rx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, start, stop, bv, qr, dr;
  logic [1:0] ttype;
  logic [7:0] b;

  logic [2:0]  rdy, wv, dv, ovf, busy;
  logic [31:0] wd0, wd2;
  logic [7:0]  wd1;
  logic [63:0] wd [3];
  logic [31:0] dd [3];

  assign wd[0] = {32'd0, wd0};
  assign wd[1] = {56'd0, wd1};
  assign wd[2] = {32'd0, wd2};

  standby_rx_packer #(.DataWidth(32), .DescWidth(32), .MaxLen(4095)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .transfer_start_i(start),
    .transfer_stop_i(stop), .transfer_type_i(ttype), .rx_byte_valid_i(bv), .rx_byte_i(b),
    .rx_byte_ready_o(rdy[0]), .rx_queue_wvalid_o(wv[0]), .rx_queue_wready_i(qr),
    .rx_queue_wdata_o(wd0), .rx_desc_queue_wvalid_o(dv[0]), .rx_desc_queue_wready_i(dr),
    .rx_desc_queue_wdata_o(dd[0]), .overflow_o(ovf[0]), .busy_o(busy[0])
  );

  standby_rx_packer #(.DataWidth(8), .DescWidth(32), .MaxLen(4095)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .transfer_start_i(start),
    .transfer_stop_i(stop), .transfer_type_i(ttype), .rx_byte_valid_i(bv), .rx_byte_i(b),
    .rx_byte_ready_o(rdy[1]), .rx_queue_wvalid_o(wv[1]), .rx_queue_wready_i(qr),
    .rx_queue_wdata_o(wd1), .rx_desc_queue_wvalid_o(dv[1]), .rx_desc_queue_wready_i(dr),
    .rx_desc_queue_wdata_o(dd[1]), .overflow_o(ovf[1]), .busy_o(busy[1])
  );

  standby_rx_packer #(.DataWidth(32), .DescWidth(32), .MaxLen(4)) u_dut_ovf (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .transfer_start_i(start),
    .transfer_stop_i(stop), .transfer_type_i(ttype), .rx_byte_valid_i(bv), .rx_byte_i(b),
    .rx_byte_ready_o(rdy[2]), .rx_queue_wvalid_o(wv[2]), .rx_queue_wready_i(qr),
    .rx_queue_wdata_o(wd2), .rx_desc_queue_wvalid_o(dv[2]), .rx_desc_queue_wready_i(dr),
    .rx_desc_queue_wdata_o(dd[2]), .overflow_o(ovf[2]), .busy_o(busy[2])
  );

  int vecs = 0;
  int errs = 0;

  // Handshake log for the instance under test
  int          mon_sel = 0;
  logic [63:0] wq [$];
  logic [31:0] dq [$];

  always @(posedge clk) begin
    if (!rst) begin
      if (wv[mon_sel] && qr) wq.push_back(wd[mon_sel]);
      if (dv[mon_sel] && dr) dq.push_back(dd[mon_sel]);
    end
  end

  typedef struct {
    int          inst;
    logic        rb;
    logic        st, sp;
    logic [1:0]  ty;
    logic        bv;
    logic [7:0]  b;
    logic        qr, dr;
    logic        e_rdy, e_wv;
    logic [63:0] e_wd;
    logic        e_dv;
    logic [31:0] e_dd;
    logic        e_ovf, e_busy;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input int inst, input logic rb, input logic st, input logic sp,
                              input logic [1:0] ty, input logic v, input logic [7:0] d,
                              input logic q, input logic r, input logic e_rdy,
                              input logic e_wv, input logic [63:0] e_wd, input logic e_dv,
                              input logic [31:0] e_dd, input logic e_ovf, input logic e_busy);
    vec_t t;
    t.inst = inst; t.rb = rb; t.st = st; t.sp = sp; t.ty = ty; t.bv = v; t.b = d;
    t.qr = q; t.dr = r; t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_wd = e_wd; t.e_dv = e_dv;
    t.e_dd = e_dd; t.e_ovf = e_ovf; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; bv = 1'b0; b = 8'h00;
    ttype = 2'd0; qr = 1'b1; dr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    dq.delete();
  endtask

  task automatic pulse(input logic is_start);
    @(negedge clk);
    if (is_start) start = 1'b1;
    else stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_byte(input int s, input logic [7:0] v, input logic [1:0] t);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      bv = 1'b1; b = v; ttype = t;
      #1 acc = rdy[s];
      @(posedge clk);
    end
    #1 bv = 1'b0;
    check("send_byte_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_idle(input int s);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      #1 idle = ~busy[s];
    end
    check("wait_idle", {63'd0, idle}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        bad;
    logic [63:0] held;
    int          idle_by;
    logic        saw_dv;
    vec_t        v;
    logic        ok;
    int          s;

    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; bv = 1'b0; b = 8'h00;
    ttype = 2'd0; qr = 1'b1; dr = 1'b1;

    // 32-bit: START, 11 22 33 44 55, STOP, type 3
    tbl.push_back(mk(0, 1, 0, 0, 2'd3, 0, 8'h00, 1, 1, 0, 0, 64'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'd3, 0, 8'h00, 1, 1, 0, 0, 64'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h11, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h22, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h33, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h44, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h55, 1, 1, 0, 1, 64'h44332211, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 1, 8'h55, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'd3, 0, 8'h00, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 0, 8'h00, 1, 1, 0, 1, 64'h55, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 0, 8'h00, 1, 1, 0, 0, 64'h0, 1, 32'h00030005, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 0, 8'h00, 1, 1, 0, 0, 64'h0, 0, 32'h0, 0, 0));
    // MaxLen=4: six bytes then STOP, overflow on byte 5 only
    tbl.push_back(mk(2, 1, 1, 0, 2'd0, 0, 8'h00, 1, 1, 0, 0, 64'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h01, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h02, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h03, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h04, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h05, 1, 1, 0, 1, 64'h04030201, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h05, 1, 1, 1, 0, 64'h0, 0, 32'h0, 1, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 1, 8'h06, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 1, 2'd0, 0, 8'h00, 1, 1, 1, 0, 64'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 0, 8'h00, 1, 1, 0, 0, 64'h0, 1, 32'h10000004, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2'd0, 0, 8'h00, 1, 1, 0, 0, 64'h0, 0, 32'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.rb) do_reset();
      @(negedge clk);
      start = v.st; stop = v.sp; ttype = v.ty; bv = v.bv; b = v.b; qr = v.qr; dr = v.dr;
      #1;
      s  = v.inst;
      ok = (rdy[s] === v.e_rdy) && (wv[s] === v.e_wv) && (!v.e_wv || wd[s] === v.e_wd) &&
           (dv[s] === v.e_dv) && (!v.e_dv || dd[s] === v.e_dd) && (ovf[s] === v.e_ovf) &&
           (busy[s] === v.e_busy);
      vecs++;
      if (!ok) begin
        errs++;
        $display("FAIL vec%0d inst%0d: got rdy=%b wv=%b wd=%h dv=%b dd=%h ovf=%b busy=%b, %s",
                 i, s, rdy[s], wv[s], wd[s], dv[s], dd[s], ovf[s], busy[s], "expected:");
        $display("  rdy=%b wv=%b wd=%h dv=%b dd=%h ovf=%b busy=%b", v.e_rdy, v.e_wv, v.e_wd,
                 v.e_dv, v.e_dd, v.e_ovf, v.e_busy);
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; bv = 1'b0;

    // 8-bit: AA BB, repeated START, CC stalled until first descriptor taken, STOP
    do_reset();
    mon_sel = 1;
    dr = 1'b0;
    pulse(1'b1);
    send_byte(1, 8'hAA, 2'd0);
    send_byte(1, 8'hBB, 2'd0);
    pulse(1'b1);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bv = 1'b1; b = 8'hCC;
      #1 if (rdy[1] !== 1'b0 || dv[1] !== 1'b1 || dd[1] !== 32'h2) bad = 1'b1;
    end
    check("rs_cc_stalled", {63'd0, bad}, 64'd0);
    dr = 1'b1;
    send_byte(1, 8'hCC, 2'd0);
    pulse(1'b0);
    wait_idle(1);
    check("rs_word_count", 64'(wq.size()), 64'd3);
    check("rs_desc_count", 64'(dq.size()), 64'd2);
    if (wq.size() == 3) begin
      check("rs_word0", wq[0], 64'hAA);
      check("rs_word1", wq[1], 64'hBB);
      check("rs_word2", wq[2], 64'hCC);
    end
    if (dq.size() == 2) begin
      check("rs_desc0", 64'(dq[0]), 64'h2);
      check("rs_desc1", 64'(dq[1]), 64'h1);
    end

    // 32-bit back-pressure on a full word for 10 cycles
    do_reset();
    mon_sel = 0;
    qr = 1'b0;
    pulse(1'b1);
    send_byte(0, 8'h01, 2'd0);
    send_byte(0, 8'h02, 2'd0);
    send_byte(0, 8'h03, 2'd0);
    send_byte(0, 8'h04, 2'd0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bv = 1'b1; b = 8'h05;
      #1 if (rdy[0] !== 1'b0 || wv[0] !== 1'b1 || wd[0] !== 64'h04030201) bad = 1'b1;
    end
    check("bp_stall_stable", {63'd0, bad}, 64'd0);
    qr = 1'b1;
    send_byte(0, 8'h05, 2'd0);
    send_byte(0, 8'h06, 2'd0);
    send_byte(0, 8'h07, 2'd0);
    send_byte(0, 8'h08, 2'd0);
    pulse(1'b0);
    wait_idle(0);
    check("bp_word_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      check("bp_word0", wq[0], 64'h04030201);
      check("bp_word1", wq[1], 64'h08070605);
    end
    check("bp_desc_count", 64'(dq.size()), 64'd1);
    if (dq.size() == 1) check("bp_desc0", 64'(dq[0]), 64'h8);

    // START then STOP with no data
    do_reset();
    mon_sel = 0;
    pulse(1'b1);
    pulse(1'b0);
    idle_by = -1;
    saw_dv  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      if (dv[0]) saw_dv = 1'b1;
      if (!busy[0] && idle_by < 0) idle_by = k;
    end
    check("empty_idle_within_2", {63'd0, idle_by >= 0}, 64'd1);
    check("empty_no_desc_valid", {63'd0, saw_dv}, 64'd0);
    check("empty_no_writes", 64'(wq.size() + dq.size()), 64'd0);

    // Asynchronous reset while a full word is waiting
    do_reset();
    mon_sel = 0;
    qr = 1'b0;
    pulse(1'b1);
    send_byte(0, 8'h01, 2'd0);
    send_byte(0, 8'h02, 2'd0);
    send_byte(0, 8'h03, 2'd0);
    send_byte(0, 8'h04, 2'd0);
    @(negedge clk);
    #1 check("rst_pre_wvalid", {63'd0, wv[0]}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {59'd0, rdy[0], wv[0], dv[0], ovf[0], busy[0]}, 64'd0);
    check("rst_async_wdata", wd[0], 64'd0);
    check("rst_async_desc", 64'(dd[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    dq.delete();
    qr = 1'b1;
    pulse(1'b1);
    send_byte(0, 8'hA1, 2'd0);
    pulse(1'b0);
    wait_idle(0);
    check("rst_after_word_count", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) check("rst_after_lane0", wq[0], 64'h000000A1);
    check("rst_after_desc_count", 64'(dq.size()), 64'd1);
    if (dq.size() == 1) check("rst_after_desc", 64'(dq[0]), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
